// File: rtl/rot_defs.sv
`default_nettype none
// ============================================================================
// Module   : rot_defs (package)
// Purpose  : Shared definitions for the rotary quadrature input conditioner:
//            FSM state encoding and default configuration constants.
// Contents : rot_state_t    - S_INIT (acquire resting position), S_RUN
//            ROT_SYNC_STAGES    - default synchroniser depth
//            ROT_DEBOUNCE_50MHZ - default debounce length (1 ms at 50 MHz)
// Revision : 1.0 - initial release
// ============================================================================
package rot_defs;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } rot_state_t;

  localparam int ROT_SYNC_STAGES    = 2;
  localparam int ROT_DEBOUNCE_50MHZ = 50000;

endpackage
`default_nettype wire

// File: rtl/rot_quad_conditioner_ch.sv
`default_nettype none
// ============================================================================
// Module   : rot_debounce_ch
// Purpose  : One quadrature channel: synchroniser chain, debounce counter and
//            accept logic producing a clean level.
// Ports    : clk        - system clock
//            reset      - asynchronous active-high reset
//            run        - high while the parent FSM is in S_RUN
//            raw        - raw pin, asynchronous to clk
//            clean_init - level to load into clean when load is high
//            load       - one-cycle strobe from the parent at end of S_INIT
//            sync_out   - synchronised raw level (last sync stage)
//            clean      - debounced level
//            accept     - high in the cycle whose edge accepts a new level
// Revision : 1.0 - initial release
// ============================================================================
module rot_debounce_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic raw,
  input  logic clean_init,
  input  logic load,
  output logic sync_out,
  output logic clean,
  output logic accept
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_clean;
  logic                   w_match;
  logic                   w_at_limit;

  assign w_match    = (r_sync[SYNC_STAGES-1] == r_clean);
  assign w_at_limit = (r_cnt == c_CNT_LAST);
  assign accept     = run & ~w_match & w_at_limit;
  assign sync_out   = r_sync[SYNC_STAGES-1];
  assign clean      = r_clean;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      if (load) begin
        r_clean <= clean_init;
        r_cnt   <= '0;
      end else if (!run || w_match) begin
        // Any return to the clean level restarts the count, so short
        // glitches never accumulate across separate mismatches.
        r_cnt <= '0;
      end else if (w_at_limit) begin
        r_clean <= r_sync[SYNC_STAGES-1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rot_quad_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : rot_quad_conditioner
// Purpose  : Synchronises and debounces the raw ROT_A/ROT_B encoder pins,
//            drives clean quadrature levels to the shaft decoder, and flags
//            clean level changes and illegal simultaneous A/B transitions.
// Ports    : clk         - system clock
//            reset       - asynchronous active-high reset
//            ROT_A/ROT_B - raw encoder pins, asynchronous to clk
//            rot_a_clean - debounced channel A
//            rot_b_clean - debounced channel B
//            rot_valid   - one-cycle pulse, a clean level changed
//            rot_err     - one-cycle pulse, both clean levels changed together
//            err_count   - saturating count of rot_err pulses
// Options  : ROT_ERR_CNT_EN - when defined, builds the saturating error
//            counter; otherwise err_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module rot_quad_conditioner
  import rot_defs::*;
#(
  parameter int SYNC_STAGES     = ROT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = ROT_DEBOUNCE_50MHZ,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ROT_A,
  input  logic       ROT_B,
  output logic       rot_a_clean,
  output logic       rot_b_clean,
  output logic       rot_valid,
  output logic       rot_err,
  output logic [7:0] err_count
);

  // The load edge is the one on which the stable count would reach
  // DEBOUNCE_CYCLES-1, so compare against one less than that.
  localparam logic [CNT_W-1:0] c_INIT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  rot_state_t       r_state;
  logic [CNT_W-1:0] r_init_cnt;
  logic [1:0]       r_prev;
  logic             r_valid;
  logic             r_err;

  logic [1:0]       w_sync_pair;
  logic             w_sync_a;
  logic             w_sync_b;
  logic             w_acc_a;
  logic             w_acc_b;
  logic             w_run;
  logic             w_stable;
  logic             w_load;

  assign w_sync_pair = {w_sync_a, w_sync_b};
  assign w_run       = (r_state == S_RUN);
  assign w_stable    = (w_sync_pair == r_prev);
  assign w_load      = (r_state == S_INIT) && w_stable && (r_init_cnt == c_INIT_LAST);

  rot_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_a (
    .clk       (clk),
    .reset     (reset),
    .run       (w_run),
    .raw       (ROT_A),
    .clean_init(w_sync_a),
    .load      (w_load),
    .sync_out  (w_sync_a),
    .clean     (rot_a_clean),
    .accept    (w_acc_a)
  );

  rot_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_b (
    .clk       (clk),
    .reset     (reset),
    .run       (w_run),
    .raw       (ROT_B),
    .clean_init(w_sync_b),
    .load      (w_load),
    .sync_out  (w_sync_b),
    .clean     (rot_b_clean),
    .accept    (w_acc_b)
  );

  // FSM, init counter and flag registers. Accepts are gated by run inside
  // the channels, so the flags stay low throughout S_INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_prev     <= 2'b00;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_prev  <= w_sync_pair;
      r_valid <= w_acc_a | w_acc_b;
      r_err   <= w_acc_a & w_acc_b;
      case (r_state)
        S_INIT: begin
          if (!w_stable) begin
            r_init_cnt <= '0;
          end else if (w_load) begin
            r_init_cnt <= '0;
            r_state    <= S_RUN;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        S_RUN: begin
          r_init_cnt <= '0;
        end
        default: begin
          r_state    <= S_INIT;
          r_init_cnt <= '0;
        end
      endcase
    end
  end

  assign rot_valid = r_valid;
  assign rot_err   = r_err;

`ifdef ROT_ERR_CNT_EN
  logic [7:0] r_err_count;

  // Counts on the same edge that raises rot_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= 8'd0;
    end else if (w_acc_a && w_acc_b && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rot_quad_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_rot_quad_conditioner
// Purpose  : Self-checking bench for rot_quad_conditioner with
//            SYNC_STAGES=2, DEBOUNCE_CYCLES=4. A window-based reference model
//            predicts clean levels and change events; a monitor compares the
//            DUT against it on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rot_quad_conditioner;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ROT_A;
  logic       ROT_B;
  logic       rot_a_clean;
  logic       rot_b_clean;
  logic       rot_valid;
  logic       rot_err;
  logic [7:0] err_count;

  rot_quad_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ROT_A      (ROT_A),
    .ROT_B      (ROT_B),
    .rot_a_clean(rot_a_clean),
    .rot_b_clean(rot_b_clean),
    .rot_valid  (rot_valid),
    .rot_err    (rot_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   edge_n;
    logic a;
    logic b;
    logic err;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state
  int         cur_edge = 0;
  bit         m_run    = 1'b0;
  logic       m_a      = 1'b0;
  logic       m_b      = 1'b0;
  int         m_errs   = 0;
  logic [1:0] dly_q[$];
  logic [1:0] win_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cur_edge, act, req);
  endtask

  task automatic fail_event(input string name);
    checks++;
    $display("FAIL %s at edge %0d: got pulse-state mismatch, expected event queue agreement", name, cur_edge);
  endtask

  // Model: the synchronised pair seen at edge k is the raw pair sampled S
  // edges earlier (zero before reset release). During acquisition the level
  // is taken once the last D seen pairs (including the reset value) agree.
  // In run, a channel flips once its last D seen values all differ from the
  // clean level.
  initial begin
    logic [1:0] s;
    bit         all_eq;
    bit         acc_a;
    bit         acc_b;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        cur_edge = 0;
        m_run    = 1'b0;
        m_a      = 1'b0;
        m_b      = 1'b0;
        m_errs   = 0;
        dly_q.delete();
        for (int i = 0; i < S; i++) dly_q.push_back(2'b00);
        win_q.delete();
        win_q.push_back(2'b00);
        exp_q.delete();
      end else begin
        cur_edge++;
        s = dly_q.pop_front();
        dly_q.push_back({ROT_A, ROT_B});
        win_q.push_back(s);
        if (win_q.size() > D) void'(win_q.pop_front());
        if (!m_run) begin
          all_eq = (win_q.size() == D);
          foreach (win_q[i]) if (win_q[i] != s) all_eq = 1'b0;
          if (all_eq) begin
            m_a   = s[1];
            m_b   = s[0];
            m_run = 1'b1;
          end
        end else begin
          acc_a = (win_q.size() == D);
          acc_b = (win_q.size() == D);
          foreach (win_q[i]) begin
            if (win_q[i][1] == m_a) acc_a = 1'b0;
            if (win_q[i][0] == m_b) acc_b = 1'b0;
          end
          if (acc_a || acc_b) begin
            if (acc_a) m_a = ~m_a;
            if (acc_b) m_b = ~m_b;
            if (acc_a && acc_b && m_errs < 255) m_errs++;
            exp_q.push_back('{cur_edge, m_a, m_b, acc_a && acc_b});
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    ev_t        ev;
    logic [7:0] exp_cnt;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_outputs", {20'd0, rot_a_clean, rot_b_clean, rot_valid, rot_err, err_count}, 32'd0);
      end else begin
`ifdef ROT_ERR_CNT_EN
        exp_cnt = 8'(m_errs);
`else
        exp_cnt = 8'd0;
`endif
        check("clean_levels", {30'd0, rot_a_clean, rot_b_clean}, {30'd0, m_a, m_b});
        check("err_count", {24'd0, err_count}, {24'd0, exp_cnt});
        if (rot_err && !rot_valid) fail_event("err_without_valid");
        while (exp_q.size() > 0 && exp_q[0].edge_n < cur_edge) begin
          void'(exp_q.pop_front());
          fail_event("missed_valid");
        end
        if (rot_valid) begin
          if (exp_q.size() == 0) begin
            fail_event("unexpected_valid");
          end else begin
            ev = exp_q.pop_front();
            check("valid_edge", cur_edge, ev.edge_n);
            check("event_err", {31'd0, rot_err}, {31'd0, ev.err});
          end
        end
      end
    end
  end

  task automatic hold(input logic a, input logic b, input int n);
    ROT_A = a;
    ROT_B = b;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input logic a, input logic b);
    reset = 1'b1;
    hold(a, b, 3);
    reset = 1'b0;
  endtask

  initial begin
    logic ra;
    logic rb;
    reset = 1'b1;
    ROT_A = 1'b0;
    ROT_B = 1'b0;
    #2;
    // Acquire a resting position of 1,1
    do_reset(1'b1, 1'b1);
    hold(1'b1, 1'b1, 12);
    // Single A rise from 0,0
    do_reset(1'b0, 1'b0);
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 12);
    // Short B glitch is rejected
    hold(1'b1, 1'b1, 3);
    hold(1'b1, 1'b0, 10);
    // Bounce on A, then settle high
    hold(1'b0, 1'b0, 12);
    for (int i = 0; i < 10; i++) hold(~ROT_A, 1'b0, 1);
    hold(1'b1, 1'b0, 12);
    // Simultaneous A/B jump
    hold(1'b0, 1'b0, 12);
    hold(1'b1, 1'b1, 12);
    // Reset mid-debounce, then re-acquire
    hold(1'b0, 1'b1, 4);
    do_reset(1'b0, 1'b1);
    hold(1'b0, 1'b1, 12);
    // Randomised encoder activity, including bounce and illegal jumps
    for (int i = 0; i < 300; i++) begin
      ra = ROT_A;
      rb = ROT_B;
      case ($urandom_range(0, 3))
        0: ra = ~ra;
        1: rb = ~rb;
        2: begin ra = ~ra; rb = ~rb; end
        default: ;
      endcase
      hold(ra, rb, $urandom_range(1, 8));
    end
    hold(ROT_A, ROT_B, 12);
    check("pending_events", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
